// File: rtl/enc_speed.sv
// enc_speed: velocity meter behind the quadrature decoder.
// Filters the asynchronous 8-bit position count, accumulates signed
// wrap-aware step deltas over a fixed window of WINDOW clocks and
// publishes the saturated result with a one-cycle valid pulse.
// Optional feature macro: ENC_SPEED_AVG_EN (4-window moving average).
module enc_speed #(
  parameter int WINDOW = 1000,
  parameter int SW     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [7:0]           cnt,
  output logic signed [SW-1:0] speed,
  output logic                 dir,
  output logic                 sat,
  output logic                 valid
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WW-1:0] WLAST = WW'(WINDOW - 1);
  // Symmetric clip limits, one bit wider than the result so sums fit.
  localparam logic signed [SW:0] MAXV = {2'b00, {(SW-1){1'b1}}};
  localparam logic signed [SW:0] MINV = -MAXV;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   run;

  logic [7:0]           s1, s2, stable, stable_nxt;
  logic signed [7:0]    d;
  logic signed [SW-1:0] acc, res;
  logic signed [SW:0]   sum;
  logic                 clip, clip_now, win_end;
  logic [WW-1:0]        wcnt;

  // Two-stage synchroniser; stable only accepts a value seen twice in a row.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the stage order does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
    end else begin
      s1     <= cnt;
      s2     <= s1;
      stable <= stable_nxt;
    end
  end

  assign stable_nxt = (s1 == s2) ? s2 : stable;

  // The registered stable value is the previous sample: the delta is taken
  // between the value being loaded and the one held, so a cnt change lands
  // in acc on the third edge. Modulo-256 subtraction handles the 255->0 wrap.
  assign d = stable_nxt - stable;

  // Saturating add of the delta into the running window sum.
  assign sum      = {acc[SW-1], acc} + {{(SW-7){d[7]}}, d};
  assign clip_now = (sum > MAXV) || (sum < MINV);
  assign res      = !clip_now ? sum[SW-1:0]
                  : (sum[SW] ? MINV[SW-1:0] : MAXV[SW-1:0]);
  assign win_end  = run && (wcnt == WLAST);

  // Mode register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: the window runs on every cycle en is sampled high.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en)  state_nxt = RUN;
      RUN:     if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    run = (state_nxt == RUN);
  end

  // Window counter, accumulator and sticky clip; all held at zero while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      clip <= 1'b0;
      wcnt <= '0;
    end else if (!run || win_end) begin
      acc  <= '0;
      clip <= 1'b0;
      wcnt <= '0;
    end else begin
      acc  <= res;
      clip <= clip | clip_now;
      wcnt <= wcnt + WW'(1);
    end
  end

`ifdef ENC_SPEED_AVG_EN
  // Previous three window results; the current one completes the set of 4.
  logic signed [SW-1:0] hist [3];
  logic [2:0]           hclip;
  logic [1:0]           nwin;
  logic signed [SW+1:0] sum4;
  logic signed [SW-1:0] avg;

  assign sum4 = {{2{hist[0][SW-1]}}, hist[0]} + {{2{hist[1][SW-1]}}, hist[1]}
              + {{2{hist[2][SW-1]}}, hist[2]} + {{2{res[SW-1]}}, res};
  assign avg  = SW'(sum4 >>> 2);

  // History shift register and count of windows completed since entering RUN.
  // NOTE: this small history is reset on purpose because stale entries would
  // leak into the average; large storage arrays normally stay unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) hist[i] <= '0;
      hclip <= '0;
      nwin  <= '0;
    end else if (!run) begin
      for (int i = 0; i < 3; i++) hist[i] <= '0;
      hclip <= '0;
      nwin  <= '0;
    end else if (win_end) begin
      hist[0] <= res;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      hclip   <= {hclip[1:0], clip | clip_now};
      if (nwin != 2'd3) nwin <= nwin + 2'd1;
    end
  end

  // Publish the 4-window average once the history is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed <= '0;
      dir   <= 1'b0;
      sat   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= win_end && (nwin == 2'd3);
      if (win_end && (nwin == 2'd3)) begin
        speed <= avg;
        dir   <= !avg[SW-1] && (avg != '0);
        sat   <= (|hclip) | clip | clip_now;
      end
    end
  end
`else
  // Publish the single-window result at the end of every window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed <= '0;
      dir   <= 1'b0;
      sat   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= win_end;
      if (win_end) begin
        speed <= res;
        dir   <= !res[SW-1] && (res != '0);
        sat   <= clip | clip_now;
      end
    end
  end
`endif

endmodule

// File: tb/tb_enc_speed.sv
// Directed testbench for enc_speed: two instances (short window, 16-bit
// result; long window, 9-bit result) with hand-computed expectations.
// The ENC_SPEED_AVG_EN build runs the moving-average scenario instead.
module tb_enc_speed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en_a, en_b;
  logic [7:0]  cnt_a, cnt_b;
  logic [15:0] speed_a;
  logic [8:0]  speed_b;
  logic        dir_a, sat_a, valid_a, dir_b, sat_b, valid_b;

  enc_speed #(.WINDOW(48), .SW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .cnt(cnt_a),
    .speed(speed_a), .dir(dir_a), .sat(sat_a), .valid(valid_a)
  );

  enc_speed #(.WINDOW(2000), .SW(9)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .cnt(cnt_b),
    .speed(speed_b), .dir(dir_b), .sat(sat_b), .valid(valid_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int vcnt_a   = 0;
  int vcnt_b   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a === 1'b1) vcnt_a <= vcnt_a + 1;
    if (valid_b === 1'b1) vcnt_b <= vcnt_b + 1;
  end

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Apply n steps of +/-1 on one instance, one step every 4 cycles.
  task automatic steps(input bit b, input int n, input int s);
    repeat (n) begin
      if (b) cnt_b = cnt_b + 8'(s);
      else   cnt_a = cnt_a + 8'(s);
      tick(4);
    end
  endtask

  task automatic wait_valid(input bit b, input int budget, output bit got,
                            output int lat);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if ((b ? valid_b : valid_a) === 1'b1) got = 1'b1;
    end
    lat = cyc;
  endtask

  task automatic expect_window(input string tag, input bit b, input int budget,
                               input int e_speed, input int e_dir, input int e_sat);
    bit got;
    int lat;
    wait_valid(b, budget, got, lat);
    check({tag, "_valid"}, got, 1);
    if (got) begin
      check({tag, "_speed"}, b ? $signed(speed_b) : $signed(speed_a), e_speed);
      check({tag, "_dir"}, b ? dir_b : dir_a, e_dir);
      check({tag, "_sat"}, b ? sat_b : sat_a, e_sat);
      @(negedge clk);
      check({tag, "_pulse"}, b ? valid_b : valid_a, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    int lat, c0, base;

    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    cnt_a = 8'h00;
    cnt_b = 8'h00;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    check("rst_speed_a", $signed(speed_a), 0);
    check("rst_dir_a", dir_a, 0);
    check("rst_sat_a", sat_a, 0);
    check("rst_speed_b", $signed(speed_b), 0);
    check("rst_no_valid", vcnt_a + vcnt_b, 0);

`ifdef ENC_SPEED_AVG_EN
    // Windows of +4, +8, 0, -4, then +1 on the 48-cycle instance.
    cnt_a = 8'h10;
    tick(6);
    base = vcnt_a;
    en_a = 1'b1;
    tick(1);
    steps(0, 4, 1);  tick(48 - 16);
    steps(0, 8, 1);  tick(48 - 32);
    tick(48);
    check("avg_suppress", vcnt_a - base, 0);
    steps(0, 4, -1);
    expect_window("avg4", 0, 60, 2, 1, 0);
    steps(0, 1, 1);
    expect_window("avg5", 0, 60, 1, 1, 0);
`else
    // Ten upward steps from 0x05 inside one window.
    cnt_a = 8'h05;
    tick(6);
    en_a = 1'b1;
    tick(1);
    steps(0, 10, 1);
    expect_window("up10", 0, 60, 10, 1, 0);
    tick(1);
    en_a  = 1'b0;
    cnt_a = 8'hFD;
    tick(6);

    // 0xFD -> 0x02 across the wrap, then back down.
    en_a = 1'b1;
    tick(1);
    steps(0, 5, 1);
    expect_window("wrap_up", 0, 60, 5, 1, 0);
    tick(1);
    en_a = 1'b0;
    tick(6);
    en_a = 1'b1;
    tick(1);
    steps(0, 5, -1);
    expect_window("wrap_dn", 0, 60, -5, 0, 0);
    tick(1);
    en_a = 1'b0;
    tick(6);

    // Partial window discarded when en drops; outputs hold.
    base = vcnt_a;
    en_a = 1'b1;
    tick(1);
    steps(0, 3, 1);
    en_a = 1'b0;
    tick(60);
    check("drop_no_valid", vcnt_a - base, 0);
    check("drop_speed_held", $signed(speed_a), -5);
    check("drop_dir_held", dir_a, 0);

    // Re-enable: first pulse WINDOW cycles later, only new steps counted.
    en_a = 1'b1;
    c0   = cyc;
    tick(1);
    steps(0, 2, 1);
    wait_valid(0, 60, got, lat);
    check("reen_valid", got, 1);
    check("reen_latency", lat - c0, 48);
    check("reen_speed", $signed(speed_a), 2);
    tick(1);
    en_a = 1'b0;
    tick(6);

    // Three-cycle latency: a step 3 edges before window end counts in it,
    // a step 2 cycles later lands in the following window.
    en_a = 1'b1;
    tick(1);
    tick(44);
    cnt_a = cnt_a + 8'd1;
    tick(2);
    cnt_a = cnt_a + 8'd1;
    expect_window("lat_in", 0, 60, 1, 1, 0);
    expect_window("lat_next", 0, 60, 1, 1, 0);

    // Reset mid-window clears outputs immediately, no pulse follows.
    tick(5);
    rst_n = 1'b0;
    #1;
    check("midrst_speed", $signed(speed_a), 0);
    check("midrst_dir", dir_a, 0);
    en_a = 1'b0;
    tick(2);
    rst_n = 1'b1;
    base  = vcnt_a;
    tick(60);
    check("midrst_no_valid", vcnt_a - base, 0);

    // 9-bit result: 300 steps clip at +255, then an empty window.
    en_b = 1'b1;
    tick(1);
    steps(1, 300, 1);
    expect_window("sat_b", 1, 1000, 255, 1, 1);
    expect_window("zero_b", 1, 2100, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
